// File: rtl/fp8_pkg.sv
// Shared FP8 field layout, limits, FSM state type and a leading-zero helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp8_pkg;

   localparam int SIGN_BIT = 7;
   localparam int EXP_W    = 3;
   localparam int FRAC_W   = 4;
   localparam int BIAS     = 3;

   localparam logic [EXP_W-1:0]        EXP_MAX = 3'd7;
   localparam logic [EXP_W+FRAC_W-1:0] MAX_MAG = 7'h7F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Leading zeros of a 5-bit mantissa (a zero input reports 4; callers screen it out).
   function automatic logic [2:0] lzc5(input logic [4:0] v);
      casez (v)
         5'b1????: lzc5 = 3'd0;
         5'b01???: lzc5 = 3'd1;
         5'b001??: lzc5 = 3'd2;
         5'b0001?: lzc5 = 3'd3;
         default:  lzc5 = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/fp8_add.sv
// FP8 adder: aligns the smaller operand with truncation, adds/subtracts, renormalizes.
// Latency: combinational.
// Backpressure: none; ovf flags saturation, unf flags an underflow flush.
module fp8_add
   import fp8_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   output logic       ovf,
   output logic       unf
);

   logic                a_zero, b_zero, swap;
   logic [7:0]          big, sml;
   logic [EXP_W-1:0]    e_big, shamt, lz;
   logic [FRAC_W:0]     m_big, m_sml, diff, norm;
   logic [FRAC_W+1:0]   tot;

   assign a_zero = (a[6:4] == '0);
   assign b_zero = (b[6:4] == '0);

   // Magnitude compare on {exp,frac}, align, combine, then renormalize.
   always_comb begin
      sum   = 8'h00;
      ovf   = 1'b0;
      unf   = 1'b0;
      swap  = (b[6:0] > a[6:0]);
      big   = swap ? b : a;
      sml   = swap ? a : b;
      e_big = big[6:4];
      shamt = e_big - sml[6:4];
      m_big = {1'b1, big[3:0]};
      m_sml = {1'b1, sml[3:0]} >> shamt;
      tot   = {1'b0, m_big} + {1'b0, m_sml};
      diff  = m_big - m_sml;
      lz    = lzc5(diff);
      norm  = diff << lz;

      if (a_zero && b_zero) begin
         sum = 8'h00;
      end else if (a_zero) begin
         sum = b;
      end else if (b_zero) begin
         sum = a;
      end else if (big[SIGN_BIT] == sml[SIGN_BIT]) begin
         if (tot[FRAC_W+1]) begin
            if (e_big == EXP_MAX) begin
               sum = {big[SIGN_BIT], MAX_MAG};
               ovf = 1'b1;
            end else begin
               sum = {big[SIGN_BIT], e_big + 3'd1, tot[4:1]};
            end
         end else begin
            sum = {big[SIGN_BIT], e_big, tot[3:0]};
         end
      end else if (diff == '0) begin
         sum = 8'h00;
      end else if (e_big <= lz) begin
         // Cancellation pushed the exponent below 1: flush to zero.
         unf = 1'b1;
         sum = 8'h00;
      end else begin
         sum = {big[SIGN_BIT], e_big - lz, norm[3:0]};
      end
   end

endmodule

// File: rtl/fp8_accumulator.sv
// Sums groups of FP8 terms (closed by in_last or MAX_TERMS) and presents the result.
// Latency: out_valid rises the cycle after the closing term is accepted.
// Backpressure: in_ready drops while a result is held; cleared by out_valid&out_ready.
// Optional: FP8_ACC_OVF_FLAG_EN adds out_ovf, a sticky per-group saturation/flush flag.
module fp8_accumulator
   import fp8_pkg::*;
#(
   parameter int MAX_TERMS = 8,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
`ifdef FP8_ACC_OVF_FLAG_EN
   output logic             out_ovf,
`endif
   output logic [CNT_W-1:0] out_count
);

   state_t           state;
   logic [7:0]       acc;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [7:0]       add_sum, load_val;
   logic             add_ovf, add_unf;
   logic             in_xfer;

   fp8_add u_add (
      .a   (acc),
      .b   (in_data),
      .sum (add_sum),
      .ovf (add_ovf),
      .unf (add_unf)
   );

   // A zero-exponent first term starts the group as a clean 8'h00.
   assign load_val  = (in_data[6:4] == '0) ? 8'h00 : in_data;
   assign cnt_inc   = cnt + 1'b1;
   assign in_xfer   = in_valid && in_ready;
   assign out_data  = acc;
   assign out_count = cnt;

   // Group FSM: load on first term, accumulate, hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         acc       <= 8'h00;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (in_xfer) begin
               acc <= load_val;
               cnt <= CNT_W'(1);
               if (in_last) begin
                  state     <= HOLD;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  state <= ACC;
               end
            end
            ACC: if (in_xfer) begin
               acc <= add_sum;
               cnt <= cnt_inc;
               if (in_last || (cnt_inc == CNT_W'(MAX_TERMS))) begin
                  state     <= HOLD;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            HOLD: if (out_ready) begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FP8_ACC_OVF_FLAG_EN
   logic ovf;

   // Sticky range flag: cleared when a group starts, set by any saturation or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_xfer && (state == IDLE)) begin
         ovf <= 1'b0;
      end else if (in_xfer && (state == ACC)) begin
         ovf <= ovf | add_ovf | add_unf;
      end
   end

   assign out_ovf = ovf;
`else
   logic unused_flags;
   assign unused_flags = &{1'b0, add_ovf, add_unf};
`endif

endmodule

// File: tb/tb_fp8_accumulator.sv
// Self-checking bench for fp8_accumulator: vector table, corner sequences, random groups.
// Latency: expects results one cycle after the closing term.
// Backpressure: exercises out_ready stalls and in_ready gating.
module tb_fp8_accumulator;

   localparam int MAX_TERMS = 8;
   localparam int CNT_W     = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_last;
   logic [7:0]       in_data;
   logic             out_valid, out_ready;
   logic [7:0]       out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int checks   = 0;
   int failures = 0;

   fp8_accumulator #(.MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef FP8_ACC_OVF_FLAG_EN
      .out_ovf   (out_ovf),
`endif
      .out_count (out_count)
   );

`ifndef FP8_ACC_OVF_FLAG_EN
   assign out_ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // ---------------- reference model (real-valued magnitudes) ----------------
   // Magnitude in units of 2^-6, the weight of the lowest fraction bit at exponent 1.
   function automatic int mag(input logic [7:0] x);
      int e;
      e = int'(x[6:4]);
      if (e == 0) return 0;
      return (16 + int'(x[3:0])) << (e - 1);
   endfunction

   task automatic encode(input int v, input logic s, output logic [7:0] r, output logic f);
      int p, e, m;
      p = 0;
      r = 8'h00;
      f = 1'b0;
      if (v == 0) return;
      for (int i = 0; i < 31; i++) if (v[i]) p = i;
      e = p - 3;
      if (e > 7) begin
         r = {s, 7'h7F};
         f = 1'b1;
      end else if (e < 1) begin
         f = 1'b1;
      end else begin
         m = v >> (e - 1);
         r = {s, 3'(e), 4'(m)};
      end
   endtask

   task automatic model_add(input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic f);
      int va, vb, vl, vs, g, v, el;
      logic sl, ss;
      va = mag(a);
      vb = mag(b);
      if (va >= vb) begin vl = va; vs = vb; sl = a[7]; ss = b[7]; el = int'(a[6:4]); end
      else          begin vl = vb; vs = va; sl = b[7]; ss = a[7]; el = int'(b[6:4]); end
      r = 8'h00;
      f = 1'b0;
      if (vl == 0) return;
      g  = 1 << (el - 1);
      vs = (vs / g) * g;
      v  = (sl == ss) ? vl + vs : vl - vs;
      encode(v, sl, r, f);
   endtask

   // ---------------- handshake helpers ----------------
   task automatic send(input logic [7:0] d, input logic last);
      bit done;
      done     = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
      end
   endtask

   task automatic recv(output logic [7:0] d, output logic [CNT_W-1:0] c, output logic f);
      bit done;
      done = 0;
      d = 8'hxx;
      c = 'x;
      f = 1'bx;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (out_valid) begin
            d = out_data;
            c = out_count;
            f = out_ovf;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL recv_timeout: out_valid stayed %0b, required 1", out_valid);
      end
   endtask

   typedef struct {
      int               n;
      logic [31:0]      t;   // term j lives in t[8*j +: 8]
      logic [7:0]       d;
      logic [CNT_W-1:0] c;
      logic             f;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [7:0]       rd, md, term;
      logic [CNT_W-1:0] rc;
      logic             rf, mf, tf, last;
      int               len;

      vecs[0]  = '{2, 32'h00003030, 8'h40, 4'd2, 1'b0};
      vecs[1]  = '{3, 32'h00303838, 8'h50, 4'd3, 1'b0};
      vecs[2]  = '{2, 32'h0000B030, 8'h00, 4'd2, 1'b0};
      vecs[3]  = '{2, 32'h00007F7F, 8'h7F, 4'd2, 1'b1};
      vecs[4]  = '{1, 32'h00000035, 8'h35, 4'd1, 1'b0};
      vecs[5]  = '{1, 32'h00000005, 8'h00, 4'd1, 1'b0};
      vecs[6]  = '{2, 32'h00000530, 8'h30, 4'd2, 1'b0};
      vecs[7]  = '{2, 32'h00009E1F, 8'h00, 4'd2, 1'b1};
      vecs[8]  = '{2, 32'h000030B8, 8'hA0, 4'd2, 1'b0};
      vecs[9]  = '{2, 32'h00001F30, 8'h37, 4'd2, 1'b0};
      vecs[10] = '{4, 32'h30303030, 8'h50, 4'd4, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;

      #7;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'h00);
      chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef FP8_ACC_OVF_FLAG_EN
      chk("rst_out_ovf",   32'(out_ovf),   32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table
      for (int v = 0; v < 11; v++) begin
         for (int j = 0; j < vecs[v].n; j++) send(vecs[v].t[8*j +: 8], j == vecs[v].n - 1);
         recv(rd, rc, rf);
         chk($sformatf("vec%0d_data", v),  32'(rd), 32'(vecs[v].d));
         chk($sformatf("vec%0d_count", v), 32'(rc), 32'(vecs[v].c));
`ifdef FP8_ACC_OVF_FLAG_EN
         chk($sformatf("vec%0d_ovf", v),   32'(rf), 32'(vecs[v].f));
`endif
      end

      // MAX_TERMS closes the group without in_last
      for (int j = 0; j < MAX_TERMS; j++) send(8'h20, 1'b0);
      @(negedge clk);
      chk("max_in_ready",  32'(in_ready),  32'd0);
      chk("max_out_valid", 32'(out_valid), 32'd1);
      recv(rd, rc, rf);
      chk("max_data",  32'(rd), 32'h50);
      chk("max_count", 32'(rc), 32'(MAX_TERMS));

      // Stall in HOLD with a new term waiting
      send(8'h30, 1'b0);
      send(8'h30, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h30;
      in_last  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("stall%0d_ready", k), 32'(in_ready),  32'd0);
         chk($sformatf("stall%0d_data", k),  32'(out_data),  32'h40);
         chk($sformatf("stall%0d_count", k), 32'(out_count), 32'd2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_post_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      recv(rd, rc, rf);
      chk("stall_next_data",  32'(rd), 32'h30);
      chk("stall_next_count", 32'(rc), 32'd1);

      // Reset mid-group
      send(8'h30, 1'b0);
      send(8'h38, 1'b0);
      #2;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data",  32'(out_data),  32'h00);
      chk("mid_rst_out_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h30, 1'b1);
      recv(rd, rc, rf);
      chk("post_rst_data",  32'(rd), 32'h30);
      chk("post_rst_count", 32'(rc), 32'd1);

      // Random groups against the reference model
      for (int g = 0; g < 200; g++) begin
         len = $urandom_range(1, MAX_TERMS);
         md  = 8'h00;
         mf  = 1'b0;
         for (int j = 0; j < len; j++) begin
            term = 8'($urandom);
            last = (j == len - 1);
            if (last && len == MAX_TERMS && $urandom_range(0, 1) == 1) last = 1'b0;
            if (j == 0) begin
               md = (term[6:4] == 3'd0) ? 8'h00 : term;
            end else begin
               model_add(md, term, md, tf);
               mf = mf | tf;
            end
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send(term, last);
         end
         recv(rd, rc, rf);
         chk($sformatf("rnd%0d_data", g),  32'(rd), 32'(md));
         chk($sformatf("rnd%0d_count", g), 32'(rc), 32'(len));
`ifdef FP8_ACC_OVF_FLAG_EN
         chk($sformatf("rnd%0d_ovf", g),   32'(rf), 32'(mf));
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp8_accumulator.md
FP8_ACCUMULATOR -- requirements
Module: fp8_accumulator

Interface
REQ-001 Parameter MAX_TERMS, default 8, maximum number of products summed per group (>=2).
REQ-002 Parameter CNT_W, default 4, width of out_count; SHALL hold MAX_TERMS.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_data/in_last valid.
REQ-006 in_ready  output  1  block can accept a term this cycle.
REQ-007 in_data  input  8  FP8 product: [7] sign, [6:4] exponent (bias 3), [3:0] fraction, implicit leading 1.
REQ-008 in_last  input  1  final term of the current group.
REQ-009 out_valid  output  1  out_data/out_count valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  8  FP8 group sum.
REQ-012 out_count  output  CNT_W  number of terms in the group.

Function
REQ-013 Transfer occurs when valid and ready are both high on the same rising edge, on either side.
REQ-014 FSM states: IDLE, ACC, HOLD.
REQ-015 IDLE: in_ready=1; accepted term loads the accumulator, count=1; go to HOLD if in_last, else ACC.
REQ-016 ACC: in_ready=1; accepted term is added to the accumulator, count+1; go to HOLD on in_last or when count reaches MAX_TERMS.
REQ-017 HOLD: in_ready=0, out_valid=1; out_data/out_count stable until out_ready; on transfer go to IDLE.
REQ-018 Latency: out_valid rises the cycle after the closing term is accepted; in_valid low in ACC leaves state unchanged.
REQ-019 Exponent field 0 means zero, whatever the fraction; zero results are emitted as 8'h00.
REQ-020 Addition: align the smaller magnitude by right shift with truncation; add or subtract by sign; the result takes the sign of the larger magnitude.
REQ-021 Normalization: carry-out gives right shift and exponent+1; cancellation gives a left shift by the leading-zero count and an exponent decrement; exact cancellation gives 8'h00.
REQ-022 Exponent overflow (>7) saturates to sign|7'h7F.
REQ-023 Exponent underflow (<1) flushes to 8'h00.
REQ-024 A single-term group outputs that term unchanged, except an exponent-0 input, which outputs 8'h00.

Reset
REQ-025 rst_n low: state=IDLE, in_ready=1, out_valid=0, out_data=8'h00, out_count=0, accumulator cleared.
REQ-026 Reset mid-group discards the partial sum; the next accepted term starts a new group.

Configuration
REQ-027 Macro FP8_ACC_OVF_FLAG_EN defined: extra output out_ovf (1 bit), sticky per group, high if any saturation or underflow flush occurred; valid with out_valid; reset 0; cleared on group start.
REQ-028 Macro undefined: no out_ovf port; saturation and flush behaviour unchanged.

Structure
REQ-029 Shared package fp8_pkg holds the field widths (SIGN_BIT, EXP_W=3, FRAC_W=4), BIAS=3, EXP_MAX=7, MAX_MAG=7'h7F and the FSM state typedef.
REQ-030 Combinational sub-module fp8_add (two FP8 in, FP8 sum plus ovf/unf out), instantiated once in the accumulate path.

Verification
REQ-031 Terms 8'h30, 8'h30(last) -> out_data 8'h40, out_count 2.
REQ-032 Terms 8'h38, 8'h38, 8'h30(last) -> out_data 8'h50, out_count 3.
REQ-033 Terms 8'h30, 8'hB0(last) -> out_data 8'h00; 8'h7F, 8'h7F(last) -> 8'h7F, and out_ovf=1 when the macro is defined.
REQ-034 MAX_TERMS=8, eight 8'h20 terms with in_last never asserted -> HOLD after the 8th term, out_data 8'h50, out_count 8.
REQ-035 out_ready held low 3 cycles in HOLD -> out_data/out_count stable, in_ready 0, incoming term not accepted until after the transfer.
REQ-036 rst_n pulsed low after 2 accepted terms -> outputs return to reset values; the following 8'h30(last) group outputs 8'h30, count 1.
